// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and slave: frame FSM states and default frame width.
package spi_pkg;

  localparam int SPI_DW_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

  // Bit counter must be able to hold DW itself, so it saturates instead of wrapping.
  function automatic int spi_cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input, with a configurable reset level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave (mode with sampling on sclk falling edge, LSB first).
// Oversamples sclk/cs/mosi with clk; reports a completed word or an aborted frame.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DW          = SPI_DW_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs,
  input  logic          mosi,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          frame_err,
  output logic          busy
);

  localparam int CW = spi_cnt_width(DW);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES);

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d_i (sclk), .q_o (sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d_i (cs), .q_o (cs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d_i (mosi), .q_o (mosi_s)
  );

  spi_state_e    state_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] dout_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          busy_q;
  logic          pend_q;
  logic          arm_q;
  logic [FW-1:0] flush_q;
  logic          sclk_prev_q;

  logic fall;
  logic last_bit;

  assign fall     = sclk_prev_q & ~sclk_s;
  assign last_bit = (count_q == CW'(DW - 1));

  // arm_q blocks a new frame until cs is seen high after the synchronizer has
  // flushed its reset levels, so a cs held low through reset cannot restart a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      arm_q       <= 1'b0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      if (flush_q != FLUSH_DONE) begin
        flush_q <= flush_q + FW'(1);
      end else if (cs_s) begin
        arm_q <= 1'b1;
      end

      if (pend_q) begin
        dout_q  <= shift_q;
        valid_q <= 1'b1;
        pend_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!cs_s && arm_q) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            count_q <= '0;
            shift_q <= '0;
          end
        end

        ST_SETUP: begin
          if (cs_s) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (fall) begin
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // A completing edge beats a simultaneous cs release; any other edge loses to it.
          if (fall && (last_bit || !cs_s)) begin
            for (int i = 0; i < DW; i++) begin
              if (count_q == CW'(i)) begin
                shift_q[i] <= mosi_s;
              end
            end
            if (count_q != CW'(DW)) begin
              count_q <= count_q + CW'(1);
            end
            if (last_bit) begin
              state_q <= ST_DONE;
              pend_q  <= 1'b1;
            end
          end else if (cs_s) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end
        end

        ST_DONE: begin
          if (cs_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Drives a 12-bit and an 8-bit receiver from one SPI master and checks both against
// a frame-level model: word complete after DW bits following a dummy edge, else abort.
module tb_spi_slave_rx;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b0;
  logic        cs   = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] dout12;
  logic [7:0]  dout8;
  logic        valid12, valid8, ferr12, ferr8, busy12, busy8;

  always #5 clk = ~clk;

  spi_slave_rx #(.DW(12), .SYNC_STAGES(SYNC)) u_dut12 (
    .clk (clk), .rst (rst), .sclk (sclk), .cs (cs), .mosi (mosi),
    .dout (dout12), .valid (valid12), .frame_err (ferr12), .busy (busy12)
  );

  spi_slave_rx #(.DW(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .clk (clk), .rst (rst), .sclk (sclk), .cs (cs), .mosi (mosi),
    .dout (dout8), .valid (valid8), .frame_err (ferr8), .busy (busy8)
  );

  typedef struct {
    bit          err;
    logic [11:0] word;
    int          cyc;
  } ev_t;

  ev_t         q12[$];
  ev_t         q8[$];
  logic [11:0] mdl12 = '0;
  logic [7:0]  mdl8  = '0;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Every cycle: pulses must match the model's queued events in order and within the
  // latency bound; dout must equal the last word the model says was delivered.
  always @(negedge clk) begin : cmp
    ev_t ev;
    if (!rst) begin
      if (valid12 || ferr12) begin
        if (q12.size() == 0) begin
          chk("dw12 unexpected pulse {valid,ferr}", {30'd0, valid12, ferr12}, 32'd0);
        end else begin
          ev = q12.pop_front();
          chk("dw12 pulse {valid,ferr}", {30'd0, valid12, ferr12}, ev.err ? 32'd1 : 32'd2);
          n_cmp++;
          if (cyc - ev.cyc > LAT) begin
            n_err++;
            $display("FAIL dw12 latency: got %0d clks, expected <= %0d", cyc - ev.cyc, LAT);
          end
          if (!ev.err) mdl12 = ev.word;
        end
      end
      if (valid8 || ferr8) begin
        if (q8.size() == 0) begin
          chk("dw8 unexpected pulse {valid,ferr}", {30'd0, valid8, ferr8}, 32'd0);
        end else begin
          ev = q8.pop_front();
          chk("dw8 pulse {valid,ferr}", {30'd0, valid8, ferr8}, ev.err ? 32'd1 : 32'd2);
          n_cmp++;
          if (cyc - ev.cyc > LAT) begin
            n_err++;
            $display("FAIL dw8 latency: got %0d clks, expected <= %0d", cyc - ev.cyc, LAT);
          end
          if (!ev.err) mdl8 = ev.word[7:0];
        end
      end
      chk("dw12 dout", 32'(dout12), 32'(mdl12));
      chk("dw8 dout", 32'(dout8), 32'(mdl8));
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input bit to12, input bit err, input logic [11:0] word);
    ev_t ev;
    ev.err  = err;
    ev.word = word;
    ev.cyc  = cyc;
    if (to12) q12.push_back(ev);
    else      q8.push_back(ev);
  endtask

  // One frame: cs low, a dummy sclk pulse, then nbits data bits and extra random bits.
  // rst_at >= 0 pulses reset just before that data bit; the rest of the frame must be ignored.
  task automatic frame(input logic [11:0] word, input int nbits, input int extra,
                       input int rst_at, input int half);
    logic [63:0] sent;
    bit          dead;
    int          total;
    sent  = '0;
    dead  = 1'b0;
    total = nbits + extra;
    mosi  = 1'($urandom);
    cs    = 1'b0;
    wait_clks(half);
    sclk = 1'b1;
    mosi = 1'($urandom);
    wait_clks(half);
    sclk = 1'b0;
    wait_clks(half);
    for (int i = 0; i < total; i++) begin
      if (i == rst_at) begin
        rst   = 1'b1;
        mdl12 = '0;
        mdl8  = '0;
        q12.delete();
        q8.delete();
        wait_clks(3);
        rst  = 1'b0;
        dead = 1'b1;
      end
      sclk = 1'b1;
      mosi = (i < nbits) ? word[i] : 1'($urandom);
      sent[i] = mosi;
      wait_clks(half);
      if (!dead && i + 1 == 12) push_ev(1'b1, 1'b0, sent[11:0]);
      if (!dead && i + 1 == 8)  push_ev(1'b0, 1'b0, {4'd0, sent[7:0]});
      sclk = 1'b0;
      wait_clks(half);
    end
    if (!dead) begin
      chk("dw12 busy in frame", 32'(busy12), 32'd1);
      chk("dw8 busy in frame", 32'(busy8), 32'd1);
      if (total < 12) push_ev(1'b1, 1'b1, 12'd0);
      if (total < 8)  push_ev(1'b0, 1'b1, 12'd0);
    end else begin
      chk("dw12 busy after reset abort", 32'(busy12), 32'd0);
      chk("dw8 busy after reset abort", 32'(busy8), 32'd0);
    end
    cs = 1'b1;
    wait_clks(2 * half + 6);
    chk("dw12 busy idle", 32'(busy12), 32'd0);
    chk("dw8 busy idle", 32'(busy8), 32'd0);
  endtask

  initial begin
    int half, mode, nb, ex;
    logic [11:0] w;

    wait_clks(4);
    rst = 1'b0;
    #2;
    chk("reset dw12 dout", 32'(dout12), 32'h0);
    chk("reset dw8 dout", 32'(dout8), 32'h0);
    chk("reset {valid,ferr,busy} dw12", {29'd0, valid12, ferr12, busy12}, 32'h0);
    chk("reset {valid,ferr,busy} dw8", {29'd0, valid8, ferr8, busy8}, 32'h0);
    wait_clks(8);

    frame(12'hA5C, 12, 0, -1, 11);
    chk("A5C dw12 dout", 32'(dout12), 32'hA5C);
    chk("A5C dw8 dout low byte", 32'(dout8), 32'h5C);

    frame(12'h001, 12, 0, -1, 6);
    chk("001 dw12 dout", 32'(dout12), 32'h001);
    frame(12'hFFF, 12, 0, -1, 6);
    chk("FFF dw12 dout", 32'(dout12), 32'hFFF);

    frame(12'h3C3, 5, 0, -1, 7);
    chk("3C3 abort dw12 dout held", 32'(dout12), 32'hFFF);
    chk("3C3 abort dw8 dout held", 32'(dout8), 32'hFF);

    frame(12'h555, 12, 20, -1, 5);
    chk("555 dw12 dout", 32'(dout12), 32'h555);
    chk("555 dw8 dout", 32'(dout8), 32'h55);

    frame(12'h7E1, 12, 0, 6, 6);
    chk("7E1 reset dw12 dout", 32'(dout12), 32'h0);
    frame(12'h123, 12, 0, -1, 6);
    chk("123 dw12 dout", 32'(dout12), 32'h123);
    chk("123 dw8 dout", 32'(dout8), 32'h23);

    frame(12'h081, 8, 0, -1, 4);
    chk("81 dw8 dout", 32'(dout8), 32'h81);
    chk("81 dw12 dout held", 32'(dout12), 32'h123);

    for (int k = 0; k < 24; k++) begin
      half = $urandom_range(4, 11);
      mode = $urandom_range(0, 2);
      w    = 12'($urandom);
      nb   = 12;
      ex   = 0;
      if (mode == 1) ex = $urandom_range(1, 5);
      if (mode == 2) nb = $urandom_range(0, 11);
      frame(w, nb, ex, -1, half);
    end

    wait_clks(20);
    chk("dw12 events outstanding", 32'(q12.size()), 32'd0);
    chk("dw8 events outstanding", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DW, default 12, frame width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs/mosi.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; fclk >= 8x sclk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sclk  input  1  serial clock from master, asynchronous to clk.
REQ-006 SHALL have port cs  input  1  chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  serial data, LSB first, updated by master on sclk rising edge.
REQ-008 SHALL have port dout  output  DW  last complete received word.
REQ-009 SHALL have port valid  output  1  one-clk pulse: dout updated.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse: cs deasserted before DW bits received.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 SHALL pass sclk, cs, mosi through SYNC_STAGES flops each before any use.
REQ-013 SHALL detect sclk falling edge as synchronized previous=1, current=0; one detection per edge.
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, DONE.
REQ-015 IDLE: on synchronized cs=0 -> SETUP; bit counter cleared to 0; shift register cleared.
REQ-016 SETUP: first sclk falling edge discarded (mosi not yet valid) -> SHIFT.
REQ-017 SHIFT: each sclk falling edge writes synchronized mosi into shift[count], count increments; LSB first.
REQ-018 SHIFT: on falling edge that stores bit DW-1 -> DONE; next clk dout <= assembled word, valid=1 for exactly one clk.
REQ-019 DONE: further sclk edges ignored; synchronized cs=1 -> IDLE.
REQ-020 SETUP or SHIFT with synchronized cs=1 -> IDLE, frame_err=1 one clk, dout and valid unchanged.
REQ-021 Falling-edge and cs=1 in same clk in SHIFT: edge sample takes priority only if it completes the word; otherwise cs=1 wins (abort).
REQ-022 count width SHALL be clog2(DW+1); no wrap, saturates at DW.
REQ-023 dout SHALL hold its value until the next valid pulse.
REQ-024 Latency: valid asserts no more than SYNC_STAGES+2 clks after the sclk falling edge sampling bit DW-1.
REQ-025 cs held low across frames SHALL NOT start a second frame; cs must return high first.

Reset
REQ-026 rst=1 SHALL force state IDLE, count 0, shift register 0, dout 0, valid 0, frame_err 0, busy 0, synchronizer flops to idle levels (sclk 0, cs 1, mosi 0).
REQ-027 rst mid-frame SHALL abort without valid or frame_err; after release a new frame requires cs high then low.

Structure
REQ-028 State enum (IDLE/SETUP/SHIFT/DONE) and default DW SHALL live in shared package spi_pkg, also used by the master.
REQ-029 Synchronizer SHALL be a sub-module sync_ff (parameter STAGES, reset value), instantiated once per input.

Verification
REQ-030 Master sends 12'hA5C, sclk = clk/22 -> one valid pulse, dout=12'hA5C, frame_err never high.
REQ-031 Back-to-back frames 12'h001 then 12'hFFF with cs high between -> two valid pulses, dout 12'h001 then 12'hFFF.
REQ-032 cs deasserted after 5 bits of 12'h3C3 -> frame_err one pulse, no valid, dout retains prior value.
REQ-033 cs held low for 20 sclk cycles after 12'h555 -> exactly one valid, dout=12'h555, busy high until cs rises.
REQ-034 rst pulsed after 6 bits of 12'h7E1, then full frame 12'h123 -> no valid/frame_err for aborted frame, then dout=12'h123.
REQ-035 DW=8 instance, byte 8'h81 -> dout=8'h81, valid pulse width 1 clk.
